// File: rtl/hacd_pkg.sv
// hawk AXI read-side shared types.
// Bus packets, arbiter debug view and state codes.
`ifndef HACD_AXI4_LEN_WIDTH
`define HACD_AXI4_LEN_WIDTH 8
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif
`ifndef HACD_AXI4_RESP_WIDTH
`define HACD_AXI4_RESP_WIDTH 2
`endif

package hacd_pkg;

  localparam int AXI_ADDR_W = 64;
  localparam int AXI_LEN_W  = `HACD_AXI4_LEN_WIDTH;
  localparam int AXI_DATA_W = `HACD_AXI4_DATA_WIDTH;
  localparam int AXI_RESP_W = `HACD_AXI4_RESP_WIDTH;
  localparam int ARB_IDX_W  = 3;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_ADDR = ARB_ADDR,
    ST_DATA = ARB_DATA
  } arb_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  arlen;
  } axi_rd_pld_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic                  arvalid;
    logic                  rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic [AXI_RESP_W-1:0] rresp;
    logic [AXI_DATA_W-1:0] rdata;
    logic                  rvalid;
    logic                  rlast;
  } axi_rd_resppkt_t;

  typedef struct packed {
    logic [1:0]           state;
    logic [ARB_IDX_W-1:0] owner;
    logic [ARB_IDX_W-1:0] rr_ptr;
    logic [AXI_LEN_W:0]   beat_cnt;
    logic                 err;
  } debug_axird_arb_t;

endpackage

// File: rtl/hawk_rr_arbiter.sv
// Combinational round-robin pick.
// First valid at or after ptr_i, wrapping.
module hawk_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] cand;

  // scan from the pointer, first hit wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      cand = pos[IDX_W-1:0];
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hawk_axird_arbiter.sv
// Round-robin share of the hawk AXI read master.
// One burst in flight; R beats routed to the owner.
module hawk_axird_arbiter
  import hacd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = AXI_LEN_W,
  parameter int DATA_W  = AXI_DATA_W,
  parameter int RESP_W  = AXI_RESP_W,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  axi_rd_pld_t     req_pld_i [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output axi_rd_resppkt_t rsp_o [NUM_REQ],
  input  logic [NUM_REQ-1:0] rsp_rready_i,
  output axi_rd_reqpkt_t  m_req_o,
  input  axi_rd_rdypkt_t  m_rdy_i,
  input  axi_rd_resppkt_t m_rsp_i,
  output logic            busy_o,
  output logic [IDX_W-1:0] owner_o,
  output logic            err_beat_o,
  input  logic            err_clr_i
);

  if (LEN_W != AXI_LEN_W || DATA_W != AXI_DATA_W ||
      RESP_W != AXI_RESP_W) begin : g_bad_w
    $error("arbiter widths differ from hacd_pkg");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_n
    $error("NUM_REQ out of range");
  end

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, rr_ptr_q, sel_idx;
  logic [NUM_REQ-1:0] sel_gnt;
  logic              sel_any;
  axi_rd_pld_t       sel_pld;
  logic [LEN_W:0]    beat_q, len_ext;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic              own_rready, hs, cnt_err, stray;
  logic [IDX_W-1:0]  ptr_nxt;

  hawk_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // payload of the granted requester and owner rready
  always_comb begin
    sel_pld    = '0;
    own_rready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_gnt[i]) sel_pld = req_pld_i[i];
      if (owner_q == IDX_W'(i)) own_rready = rsp_rready_i[i];
    end
  end

  // R channel routed only to the owner during DATA
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_o[i] = '0;
      if (state_q == ST_DATA && owner_q == IDX_W'(i)) begin
        rsp_o[i] = m_rsp_i;
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) ? sel_gnt : '0;
  assign len_ext  = {1'b0, len_q};
  assign hs       = (state_q == ST_DATA) && m_rsp_i.rvalid && own_rready;
  assign stray    = (state_q != ST_DATA) && m_rsp_i.rvalid;
  assign cnt_err  = hs && (m_rsp_i.rlast ? (beat_q != len_ext)
                                         : (beat_q == len_ext));
  assign ptr_nxt  = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  assign m_req_o.addr    = addr_q;
  assign m_req_o.arlen   = len_q;
  assign m_req_o.arvalid = (state_q == ST_ADDR);
  assign m_req_o.rready  = (state_q == ST_DATA) && own_rready;

  assign busy_o     = (state_q != ST_IDLE);
  assign owner_o    = owner_q;
  assign err_beat_o = err_q;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sel_any) state_d = ST_ADDR;
      ST_ADDR: if (m_rdy_i.arready) state_d = ST_DATA;
      ST_DATA: if (hs && m_rsp_i.rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // grant capture, beat counting and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && sel_any) begin
        owner_q <= sel_idx;
        addr_q  <= sel_pld.addr;
        len_q   <= sel_pld.arlen;
      end
      if (state_q == ST_ADDR && m_rdy_i.arready) beat_q <= '0;
      if (hs) beat_q <= beat_q + 1'b1;
      if (hs && m_rsp_i.rlast) rr_ptr_q <= ptr_nxt;
    end
  end

  // sticky beat error; a new error beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               err_q <= 1'b0;
    else if (cnt_err || stray) err_q <= 1'b1;
    else if (err_clr_i)        err_q <= 1'b0;
  end

endmodule

// File: tb/tb_hawk_axird_arbiter.sv
// Bench for hawk_axird_arbiter.
// Scoreboard of expected R beats per burst.
module tb_hawk_axird_arbiter;
  import hacd_pkg::*;

  localparam int NREQ = 4;

  typedef struct {
    int                    own;
    logic [AXI_DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axi_rd_pld_t     req_pld [NREQ];
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  axi_rd_resppkt_t rsp [NREQ];
  logic [NREQ-1:0] rsp_rready;
  axi_rd_reqpkt_t  m_req;
  axi_rd_rdypkt_t  m_rdy;
  axi_rd_resppkt_t m_rsp;
  logic            busy;
  logic [1:0]      owner;
  logic            err;
  logic            err_clr;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];

  hawk_axird_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_pld_i    (req_pld),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .rsp_o        (rsp),
    .rsp_rready_i (rsp_rready),
    .m_req_o      (m_req),
    .m_rdy_i      (m_rdy),
    .m_rsp_i      (m_rsp),
    .busy_o       (busy),
    .owner_o      (owner),
    .err_beat_o   (err),
    .err_clr_i    (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [AXI_DATA_W-1:0] obs,
                     input logic [AXI_DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    rsp_rready = '0;
    m_rdy      = '0;
    m_rsp      = '0;
    err_clr    = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [NREQ-1:0] v, input int g,
                       input bit hold);
    logic [NREQ-1:0] oh;
    oh        = '0;
    oh[g]     = 1'b1;
    req_valid = v;
    #1;
    chk("accept", req_ready, oh);
    @(negedge clk);
    if (!hold) req_valid = '0;
    chk("owner", owner, g);
    chk("busy", busy, 1);
    chk("ready_drop", req_ready, 0);
  endtask

  task automatic addr_phase(input int dly, input axi_rd_pld_t p,
                            output int nav);
    nav = 0;
    for (int t = 0; t < 64; t++) begin
      if (m_req.arvalid) begin
        nav++;
        if (nav == 1) begin
          chk("araddr", m_req.addr, p.addr);
          chk("arlen", m_req.arlen, p.arlen);
        end
        m_rdy.arready = (nav > dly);
      end
      @(negedge clk);
      if (m_rdy.arready) begin
        m_rdy.arready = 1'b0;
        return;
      end
    end
    chk("ar_timeout", 1, 0);
  endtask

  task automatic run_burst(input int own, input int nb, input int last_at,
                           input bit bp, output int cyc, output int nhs);
    int   k;
    int   obs;
    int   nv;
    exp_t e;
    k   = 0;
    cyc = 0;
    nhs = 0;
    while (k < nb && cyc < 64) begin
      m_rsp.rvalid = 1'b1;
      m_rsp.rresp  = 2'(k);
      m_rsp.rdata  = AXI_DATA_W'({32'(own), 32'(k), 32'hBEEF_0000});
      m_rsp.rlast  = (k == last_at);
      rsp_rready      = '0;
      rsp_rready[own] = bp ? ~cyc[0] : 1'b1;
      if (sb.size() == 0) sb.push_back('{own, m_rsp.rdata});
      #1;
      chk("m_rready", m_req.rready, rsp_rready[own]);
      obs = -1;
      nv  = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (rsp[i].rvalid) begin
          obs = i;
          nv++;
        end
      end
      chk("rvalid_cnt", nv, 1);
      if (obs >= 0 && rsp_rready[obs]) begin
        e = sb.pop_front();
        chk("route_own", obs, e.own);
        chk("rdata", rsp[obs].rdata, e.data);
        k++;
        nhs++;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < nb) chk("burst_timeout", k, nb);
    m_rsp      = '0;
    rsp_rready = '0;
  endtask

  int nav;
  int cyc;
  int nhs;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_pld[i].addr  = 64'h1000 * (i + 1);
      req_pld[i].arlen = 8'd3;
    end
    do_reset();

    // reset values
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mreq", m_req, 0);
    for (int i = 0; i < NREQ; i++) chk("rst_rsp", rsp[i], 0);

    // single request on requester 1
    req_pld[1].addr  = 64'hFF_F610_0000;
    req_pld[1].arlen = 8'd0;
    issue(4'b0010, 1, 0);
    addr_phase(2, req_pld[1], nav);
    chk("arvalid_cycles", nav, 3);
    run_burst(1, 1, 0, 0, cyc, nhs);
    chk("single_err", err, 0);
    chk("single_idle", busy, 0);
    req_valid = 4'b0101;
    #1;
    chk("rr_ptr2", req_ready, 4'b0100);
    req_valid = '0;
    @(negedge clk);

    // contention, all valids held
    req_pld[1].addr  = 64'h2000;
    req_pld[1].arlen = 8'd3;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      issue(4'b1111, b % NREQ, 1);
      addr_phase(0, req_pld[b % NREQ], nav);
      run_burst(b % NREQ, 4, 3, 0, cyc, nhs);
      chk("cont_beats", nhs, 4);
    end
    req_valid = '0;
    chk("cont_err", err, 0);
    @(negedge clk);

    // backpressure on requester 3
    issue(4'b1000, 3, 0);
    addr_phase(1, req_pld[3], nav);
    run_burst(3, 4, 3, 1, cyc, nhs);
    chk("bp_cycles", cyc, 7);
    chk("bp_err", err, 0);

    // rlast early on requester 0
    issue(4'b0001, 0, 0);
    addr_phase(0, req_pld[0], nav);
    run_burst(0, 2, 1, 0, cyc, nhs);
    chk("mis_err", err, 1);
    chk("mis_idle", busy, 0);
    repeat (2) @(negedge clk);
    chk("mis_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("mis_clr", err, 0);

    // stray beat in IDLE with a clear in the same cycle
    m_rsp.rvalid = 1'b1;
    m_rsp.rlast  = 1'b1;
    err_clr      = 1'b1;
    rsp_rready   = '1;
    #1;
    chk("stray_rready", m_req.rready, 0);
    chk("stray_route", rsp[0].rvalid, 0);
    @(negedge clk);
    m_rsp      = '0;
    rsp_rready = '0;
    err_clr    = 1'b0;
    chk("stray_err", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("stray_clr", err, 0);

    // reset during the second beat of a burst
    issue(4'b0100, 2, 0);
    addr_phase(0, req_pld[2], nav);
    m_rsp.rvalid  = 1'b1;
    m_rsp.rdata   = AXI_DATA_W'(64'hA5);
    rsp_rready[2] = 1'b1;
    @(negedge clk);
    m_rsp.rdata = AXI_DATA_W'(64'hA6);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_mreq", m_req, 0);
    chk("mrst_rsp", rsp[2], 0);
    chk("mrst_err", err, 0);
    m_rsp      = '0;
    rsp_rready = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_pld[0].arlen = 8'd0;
    issue(4'b1001, 0, 0);
    addr_phase(0, req_pld[0], nav);
    run_burst(0, 1, 0, 0, cyc, nhs);
    chk("post_rst_beats", nhs, 1);
    chk("post_rst_err", err, 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
